// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit: forward selects,
// mult/div occupancy states and register-match helpers.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int MD_LATENCY_DEFAULT = 5;
    localparam int MD_CNT_W           = 4;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic fwd_sel_t fwd_sel(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       wr_m,
        input logic [4:0] dst_w,
        input logic       wr_w
    );
        if (wr_m && reg_match(src, dst_m)) return FWD_MEM;
        if (wr_w && reg_match(src, dst_w)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy tracker: busy for LATENCY cycles after start,
// a start while busy restarts the full count.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] RELOAD = MD_CNT_W'(LATENCY - 1);

    md_state_t             state;
    logic [MD_CNT_W-1:0]   count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            count <= '0;
        end else if (start) begin
            state <= MD_BUSY;
            count <= RELOAD;
        end else if (state == MD_BUSY) begin
            if (count == '0) begin
                state <= MD_IDLE;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects plus stall/flush generation.
// Define HAZARD_FORWARD_EN to enable forwarding; without it every dependency stalls.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemToRegE,
    input  logic       BranchD,
    input  logic       MfHiLoD,
    input  logic       MdStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       MdBusy
);

    logic [4:0] WriteRegM, WriteRegW;
    logic       RegWriteM, MemToRegM, RegWriteW;
    logic       d_hits_e, d_hits_m, dep_stall, md_stall, stall;

    // Shadow of the E->M->W destination fields; a flush turns the M slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            WriteRegM <= '0;
            RegWriteM <= 1'b0;
            MemToRegM <= 1'b0;
            WriteRegW <= '0;
            RegWriteW <= 1'b0;
        end else begin
            WriteRegM <= WriteRegE;
            RegWriteM <= RegWriteE && !FlushE;
            MemToRegM <= MemToRegE && !FlushE;
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
        end
    end

    assign d_hits_e = reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE);
    assign d_hits_m = reg_match(RsD, WriteRegM) || reg_match(RtD, WriteRegM);

`ifdef HAZARD_FORWARD_EN
    assign ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
    assign ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);

    // Load-use in E, or a branch compare that cannot yet see an E result or M load.
    assign dep_stall = (MemToRegE && RegWriteE && d_hits_e)
                     || (BranchD && ((RegWriteE && d_hits_e)
                                     || (MemToRegM && RegWriteM && d_hits_m)));
`else
    logic unused_fwd_inputs;

    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;
    assign ForwardAD = 1'b0;
    assign ForwardBD = 1'b0;
    assign unused_fwd_inputs = ^{RsE, RtE, BranchD, MemToRegM, WriteRegW, RegWriteW};

    assign dep_stall = (RegWriteE && d_hits_e) || (RegWriteM && d_hits_m);
`endif

    assign md_stall = MfHiLoD && (MdBusy || MdStartE);
    assign stall    = dep_stall || md_stall;
    assign StallF   = stall;
    assign StallD   = stall;
    assign FlushE   = stall;

    md_busy_counter #(
        .LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (MdStartE),
        .busy  (MdBusy)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE;
    logic       RegWriteE, MemToRegE, BranchD, MfHiLoD, MdStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] expected;
    logic [9:0] observed;

    always #5 clk = ~clk;

    hazard_unit #(.MD_LATENCY(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegE (WriteRegE),
        .RegWriteE (RegWriteE),
        .MemToRegE (MemToRegE),
        .BranchD   (BranchD),
        .MfHiLoD   (MfHiLoD),
        .MdStartE  (MdStartE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .MdBusy    (MdBusy)
    );

    assign observed = {StallF, StallD, FlushE, MdBusy, ForwardAE, ForwardBE, ForwardAD, ForwardBD};

    // Layout: {StallF, StallD, FlushE, MdBusy, ForwardAE, ForwardBE, ForwardAD, ForwardBD}
    function automatic logic [9:0] pack(input logic stall, input logic busy,
                                        input logic [1:0] fae, input logic [1:0] fbe,
                                        input logic fad, input logic fbd);
        return {stall, stall, stall, busy, fae, fbe, fad, fbd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0; WriteRegE = '0;
        RegWriteE = 1'b0; MemToRegE = 1'b0; BranchD = 1'b0;
        MfHiLoD = 1'b0; MdStartE = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        RegWriteE = 1'b1; WriteRegE = 5'd3;
        tick();
        reset = 1'b1; RegWriteE = 1'b0; WriteRegE = 5'd0;
        tick();
        reset = 1'b0;
        RsE = 5'd3; RtE = 5'd3; RsD = 5'd3; RtD = 5'd3;
        #1;
        expected = pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL reset_clears_pipe: got %b expected %b", observed, expected);
        end
        RsE = 5'd0; RtE = 5'd0; RtD = 5'd0; RsD = 5'd4;
        MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd4;
        #1;
        expected = pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL reset_input_stall: got %b expected %b", observed, expected);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        #1;
        expected = pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL lw_stall: got %b expected %b", observed, expected);
        end
        tick();
        // The flushed edge leaves a bubble in M, so the stall lasts exactly one cycle.
        clear_inputs();
        RsE = 5'd8;
        #1;
        expected = pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL lw_stall_released: got %b expected %b", observed, expected);
        end
        MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0; RsE = 5'd0;
        #1;
        expected = pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL lw_r0_no_stall: got %b expected %b", observed, expected);
        end
        WriteRegE = 5'd8; RsD = 5'd2;
        tick();
        clear_inputs();
        RsE = 5'd8; RsD = 5'd8;
        #1;
        expected = FWD ? pack(1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0)
                       : pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL lw_forward_mem: got %b expected %b", observed, expected);
        end
        clear_inputs();
    endtask

    task automatic test_alu_chain();
        do_reset();
        RegWriteE = 1'b1; WriteRegE = 5'd3;
        tick();
        tick();
        clear_inputs();
        RsE = 5'd3; RtE = 5'd3; RsD = 5'd3;
        #1;
        expected = FWD ? pack(1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0)
                       : pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL alu_mem_priority: got %b expected %b", observed, expected);
        end
        tick();
        RtE = 5'd0;
        #1;
        expected = FWD ? pack(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0)
                       : pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL alu_wb_only: got %b expected %b", observed, expected);
        end
        RsE = 5'd0; RsD = 5'd0; RtD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
        #1;
        expected = FWD ? pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0)
                       : pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL alu_pending_e: got %b expected %b", observed, expected);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        BranchD = 1'b1; RsD = 5'd1; RtD = 5'd5; RegWriteE = 1'b1; WriteRegE = 5'd5;
        #1;
        expected = pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL branch_alu_e: got %b expected %b", observed, expected);
        end
        tick();
        clear_inputs();
        BranchD = 1'b1; RtD = 5'd5;
        #1;
        expected = pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL branch_released: got %b expected %b", observed, expected);
        end
        clear_inputs();
        RegWriteE = 1'b1; WriteRegE = 5'd5;
        tick();
        clear_inputs();
        BranchD = 1'b1; RtD = 5'd5;
        #1;
        expected = FWD ? pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1)
                       : pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL branch_forward_bd: got %b expected %b", observed, expected);
        end
        clear_inputs();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd6;
        tick();
        clear_inputs();
        BranchD = 1'b1; RsD = 5'd6;
        #1;
        expected = FWD ? pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0)
                       : pack(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL branch_load_m: got %b expected %b", observed, expected);
        end
        clear_inputs();
    endtask

    task automatic test_mult_div();
        logic start, mf, busy_exp;
        do_reset();
        // Single issue; cycle 2 drops MfHiLoD to show busy alone does not stall.
        for (int k = 0; k < 8; k++) begin
            start = (k == 0);
            mf = (k != 2);
            MdStartE = start; MfHiLoD = mf;
            #1;
            busy_exp = (k >= 1) && (k <= 5);
            expected = pack(mf && (busy_exp || start), busy_exp, 2'b00, 2'b00, 1'b0, 1'b0);
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL md_single cycle %0d: got %b expected %b", k, observed, expected);
            end
            tick();
        end
        do_reset();
        for (int k = 0; k < 11; k++) begin
            start = (k == 0) || (k == 3);
            MdStartE = start; MfHiLoD = 1'b1;
            #1;
            busy_exp = (k >= 1) && (k <= 8);
            expected = pack(busy_exp || start, busy_exp, 2'b00, 2'b00, 1'b0, 1'b0);
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL md_restart cycle %0d: got %b expected %b", k, observed, expected);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        MfHiLoD = 1'b1; MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        tick();
        expected = pack(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL md_busy_before_reset: got %b expected %b", observed, expected);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        expected = pack(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL md_reset_abort: got %b expected %b", observed, expected);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_alu_chain();
        test_branch();
        test_mult_div();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
